// File: rtl/onchip_dpram_ctrl.sv
// Dual-port Avalon-MM RAM with post-reset clear sequencer, collision policy and counter.
// Optional per-lane even parity is enabled by defining ONCHIP_DPRAM_PARITY_EN.
//
// state    | meaning
// ST_IDLE  | transient one-cycle hop to CLEAR/READY
// ST_CLEAR | writing INIT_VALUE to ptr_q, ports stalled
// ST_READY | ports accept requests
module onchip_dpram_ctrl #(
  parameter int                DATA_W        = 16,
  parameter int                ADDR_W        = 15,
  parameter int                BE_W          = DATA_W / 8,
  parameter int                READ_LATENCY  = 1,
  parameter int                INIT_ON_RESET = 1,
  parameter logic [DATA_W-1:0] INIT_VALUE    = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reset_req,
  input  logic [ADDR_W-1:0] address,
  input  logic [BE_W-1:0]   byteenable,
  input  logic              chipselect,
  input  logic              write,
  input  logic [DATA_W-1:0] writedata,
  input  logic              clken,
  output logic [DATA_W-1:0] readdata,
  output logic              readdatavalid,
  output logic              waitrequest,
  input  logic [ADDR_W-1:0] address2,
  input  logic [BE_W-1:0]   byteenable2,
  input  logic              chipselect2,
  input  logic              write2,
  input  logic [DATA_W-1:0] writedata2,
  input  logic              clken2,
  output logic [DATA_W-1:0] readdata2,
  output logic              readdatavalid2,
  output logic              waitrequest2,
  output logic              init_busy,
  output logic              collision,
  output logic [15:0]       collision_count
`ifdef ONCHIP_DPRAM_PARITY_EN
  ,
  input  logic              parity_inject,
  output logic              parity_err,
  output logic              parity_err2
`endif
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_READY} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic              busy_q;
  logic              wait_q;
  logic              coll_q;
  logic              coll_d;
  logic [15:0]       cnt_q;
  logic [15:0]       cnt_d;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Port-indexed views: index 0 is s1, index 1 is s2.
  logic [ADDR_W-1:0] addr_w  [2];
  logic [BE_W-1:0]   be_w    [2];
  logic [DATA_W-1:0] wdata_w [2];
  logic [1:0]        cs_w, wr_w, ce_w;
  logic [1:0]        acc, rd_acc, wr_acc, adv;

  logic [DATA_W-1:0] s_data_q [2];
  logic [DATA_W-1:0] rdata_q  [2];
  logic [1:0]        s_v_q;
  logic [1:0]        rvalid_q;

`ifdef ONCHIP_DPRAM_PARITY_EN
  logic [BE_W-1:0] par_q   [DEPTH];
  logic [BE_W-1:0] s_par_q [2];
  logic [1:0]      rerr_q;

  function automatic logic [BE_W-1:0] lane_par(input logic [DATA_W-1:0] d);
    logic [BE_W-1:0] r;
    for (int b = 0; b < BE_W; b++) r[b] = ^d[8*b +: 8];
    return r;
  endfunction
`endif

  assign addr_w[0]  = address;
  assign addr_w[1]  = address2;
  assign be_w[0]    = byteenable;
  assign be_w[1]    = byteenable2;
  assign wdata_w[0] = writedata;
  assign wdata_w[1] = writedata2;
  assign cs_w       = {chipselect2, chipselect};
  assign wr_w       = {write2, write};
  assign ce_w       = {clken2, clken};

  always_comb begin
    acc    = '0;
    rd_acc = '0;
    wr_acc = '0;
    adv    = '0;
    for (int p = 0; p < 2; p++) begin
      acc[p]    = (state_q == ST_READY) & cs_w[p] & ce_w[p] & ~reset_req & ~reset;
      rd_acc[p] = acc[p] & ~wr_w[p];
      wr_acc[p] = acc[p] & wr_w[p];
      adv[p]    = ce_w[p] & ~reset_req;
    end
  end

  always_comb begin
    coll_d = wr_acc[0] & wr_acc[1] & (addr_w[0] == addr_w[1]);
    cnt_d  = cnt_q;
    if (coll_d && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= (INIT_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      ptr_q   <= '0;
      busy_q  <= (INIT_ON_RESET != 0);
      wait_q  <= (INIT_ON_RESET != 0);
      coll_q  <= 1'b0;
      cnt_q   <= '0;
    end else if (!reset_req) begin
      case (state_q)
        ST_IDLE: begin
          ptr_q   <= '0;
          state_q <= (INIT_ON_RESET != 0) ? ST_CLEAR : ST_READY;
          busy_q  <= (INIT_ON_RESET != 0);
          wait_q  <= (INIT_ON_RESET != 0);
        end
        ST_CLEAR: begin
          ptr_q <= ptr_q + 1'b1;
          if (ptr_q == ADDR_W'(DEPTH - 1)) begin
            state_q <= ST_READY;
            busy_q  <= 1'b0;
            wait_q  <= 1'b0;
          end
        end
        default: state_q <= ST_READY;
      endcase
      coll_q <= coll_d;
      cnt_q  <= cnt_d;
    end
  end

  // s2 is written first so that s1 overrides lanes both ports enable.
  always_ff @(posedge clk) begin
    if (!reset && !reset_req) begin
      if (state_q == ST_CLEAR) begin
        mem_q[ptr_q] <= INIT_VALUE;
`ifdef ONCHIP_DPRAM_PARITY_EN
        par_q[ptr_q] <= lane_par(INIT_VALUE);
`endif
      end else begin
        for (int p = 1; p >= 0; p--) begin
          if (wr_acc[p]) begin
            for (int b = 0; b < BE_W; b++) begin
              if (be_w[p][b]) begin
                mem_q[addr_w[p]][8*b +: 8] <= wdata_w[p][8*b +: 8];
`ifdef ONCHIP_DPRAM_PARITY_EN
                par_q[addr_w[p]][b] <= (^wdata_w[p][8*b +: 8]) ^ (p == 0 && parity_inject);
`endif
              end
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int p = 0; p < 2; p++) begin
        s_data_q[p] <= '0;
        rdata_q[p]  <= '0;
      end
      s_v_q    <= '0;
      rvalid_q <= '0;
`ifdef ONCHIP_DPRAM_PARITY_EN
      for (int p = 0; p < 2; p++) s_par_q[p] <= '0;
      rerr_q <= '0;
`endif
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (adv[p]) begin
          if (READ_LATENCY == 2) begin
            s_v_q[p]    <= rd_acc[p];
            rvalid_q[p] <= s_v_q[p];
            if (rd_acc[p]) s_data_q[p] <= mem_q[addr_w[p]];
            if (s_v_q[p])  rdata_q[p]  <= s_data_q[p];
`ifdef ONCHIP_DPRAM_PARITY_EN
            if (rd_acc[p]) s_par_q[p] <= par_q[addr_w[p]];
            rerr_q[p] <= s_v_q[p] && (lane_par(s_data_q[p]) != s_par_q[p]);
`endif
          end else begin
            rvalid_q[p] <= rd_acc[p];
            if (rd_acc[p]) rdata_q[p] <= mem_q[addr_w[p]];
`ifdef ONCHIP_DPRAM_PARITY_EN
            rerr_q[p] <= rd_acc[p] && (lane_par(mem_q[addr_w[p]]) != par_q[addr_w[p]]);
`endif
          end
        end
      end
    end
  end

  assign readdata        = rdata_q[0];
  assign readdata2       = rdata_q[1];
  assign readdatavalid   = rvalid_q[0];
  assign readdatavalid2  = rvalid_q[1];
  assign waitrequest     = wait_q;
  assign waitrequest2    = wait_q;
  assign init_busy       = busy_q;
  assign collision       = coll_q;
  assign collision_count = cnt_q;
`ifdef ONCHIP_DPRAM_PARITY_EN
  assign parity_err      = rerr_q[0];
  assign parity_err2     = rerr_q[1];
`endif

endmodule
